// File: rtl/wb_timer_defs.sv
// Shared register map, CTRL bit positions and widths for the Wishbone timer,
// used by the RTL, firmware headers and the bench.
`timescale 1ns/1ps
package wb_timer_defs;
  localparam int DATA_W      = 32;
  localparam int PRESCALE_W  = 16;
  localparam int CTRL_W      = 3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STATUS_PEND = 0;

  // Word index decoded from adr[4:2]; indices 5-7 are unmapped.
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_LOAD     = 3'd1,
    REG_COUNT    = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_idx_e;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [DATA_W/8-1:0] sel);
    logic [DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/wb_timer_core.sv
// Prescaler and 32-bit down-counter; flags expiry when a tick finds COUNT at zero.
`timescale 1ns/1ps
module wb_timer_core
  import wb_timer_defs::*;
#(
  parameter logic [DATA_W-1:0] LOAD_RST = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DATA_W-1:0]     load,
  input  logic                  count_we,
  input  logic [DATA_W-1:0]     count_wdata,
  output logic [DATA_W-1:0]     count,
  output logic                  expire
);
  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;

  // An equality compare means a PRESCALE lowered below pcnt waits for the 16-bit wrap.
  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      count <= LOAD_RST;
    end else begin
      if (!en || tick) pcnt <= '0;
      else             pcnt <= pcnt + 1'b1;

      // A bus write to COUNT overrides whatever the tick would have done.
      if (count_we) begin
        count <= count_wdata;
      end else if (tick) begin
        if (count != '0)      count <= count - 1'b1;
        else if (auto_reload) count <= load;
      end
    end
  end
endmodule

// File: rtl/wb_timer.sv
// Wishbone classic timer: bus decode, register file and interrupt, around wb_timer_core.
`timescale 1ns/1ps
module wb_timer
  import wb_timer_defs::*;
#(
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = 16'h0000,
  parameter logic [DATA_W-1:0]     LOAD_RST     = 32'h0000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [DATA_W-1:0] wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  output logic              wbs_ack_o,
  output logic              irq_o
);
  logic [2:0]            addr;
  logic                  access, wr, rd, count_we, expire;
  logic [CTRL_W-1:0]     ctrl, ctrl_nxt;
  logic                  pend, pend_nxt;
  logic [DATA_W-1:0]     load, count, rdata;
  logic [PRESCALE_W-1:0] prescale;
  logic                  unused_adr;

  assign addr       = wbs_adr_i[4:2];
  assign unused_adr = ^{wbs_adr_i[DATA_W-1:5], wbs_adr_i[1:0]};
  // Gating on !ack makes every access exactly two cycles, even with stb held.
  assign access     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr         = access & wbs_we_i;
  assign rd         = access & ~wbs_we_i;
  assign count_we   = wr && (addr == REG_COUNT);

  wb_timer_core #(.LOAD_RST(LOAD_RST)) core (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_ni),
    .en          (ctrl[CTRL_EN]),
    .auto_reload (ctrl[CTRL_AUTO]),
    .prescale    (prescale),
    .load        (load),
    .count_we    (count_we),
    .count_wdata (byte_merge(count, wbs_dat_i, wbs_sel_i)),
    .count       (count),
    .expire      (expire)
  );

  // Bus writes to CTRL beat the one-shot EN clear; a hardware PEND set beats W1C.
  always_comb begin
    ctrl_nxt = ctrl;
    pend_nxt = pend;
    if (expire && !ctrl[CTRL_AUTO]) ctrl_nxt[CTRL_EN] = 1'b0;
    if (wr && (addr == REG_CTRL) && wbs_sel_i[0]) ctrl_nxt = wbs_dat_i[CTRL_W-1:0];
    if (wr && (addr == REG_STATUS) && wbs_sel_i[0] && wbs_dat_i[STATUS_PEND]) pend_nxt = 1'b0;
    if (expire) pend_nxt = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:     rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
      REG_LOAD:     rdata = load;
      REG_COUNT:    rdata = count;
      REG_STATUS:   rdata = {{(DATA_W-1){1'b0}}, pend};
      REG_PRESCALE: rdata = {{(DATA_W-PRESCALE_W){1'b0}}, prescale};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
      ctrl      <= '0;
      pend      <= 1'b0;
      load      <= LOAD_RST;
      prescale  <= PRESCALE_RST;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd ? rdata : '0;
      ctrl      <= ctrl_nxt;
      pend      <= pend_nxt;
      irq_o     <= pend_nxt & ctrl_nxt[CTRL_IRQ_EN];
      if (wr && (addr == REG_LOAD)) load <= byte_merge(load, wbs_dat_i, wbs_sel_i);
      if (wr && (addr == REG_PRESCALE)) begin
        if (wbs_sel_i[0]) prescale[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) prescale[15:8] <= wbs_dat_i[15:8];
      end
    end
  end
endmodule

// File: tb/tb_wb_timer.sv
// Randomised and directed bench for wb_timer against a behavioural register/timer model.
`timescale 1ns/1ps
module tb_wb_timer;
  import wb_timer_defs::*;

  logic        clk, rst_n;
  logic [31:0] adr, wdat, rdat;
  logic        we, stb, cyc, ack, irq;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit cmp_on = 1'b1;

  wb_timer #(.PRESCALE_RST(16'h0003), .LOAD_RST(32'h0000_0010)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_dat_o(rdat), .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb),
    .wbs_cyc_i(cyc), .wbs_ack_o(ack), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  initial begin
    #1500us;
    $display("FAIL global_timeout cycles=%0d required=finish", cyc_n);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ack, m_pend, m_irq;
  logic [31:0] m_dat, m_load, m_count;
  logic [2:0]  m_ctrl;
  int          m_pre, m_pcnt;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    m_ack = 0; m_dat = 0; m_irq = 0; m_pend = 0; m_ctrl = 0; m_pcnt = 0;
    m_load = 32'h10; m_count = 32'h10; m_pre = 3;
  endtask

  task automatic m_step();
    logic acc, tick, expire, n_pend;
    logic [31:0] rdv, n_count;
    logic [2:0] n_ctrl;
    int idx, n_pcnt;
    acc    = cyc && stb && !m_ack;
    idx    = int'(adr[4:2]);
    tick   = m_ctrl[0] && (m_pcnt == m_pre);
    expire = tick && (m_count == 0);
    case (idx)
      0: rdv = {29'b0, m_ctrl};
      1: rdv = m_load;
      2: rdv = m_count;
      3: rdv = {31'b0, m_pend};
      4: rdv = 32'(m_pre);
      default: rdv = 0;
    endcase
    n_pcnt  = (m_ctrl[0] && !tick) ? (m_pcnt + 1) % 65536 : 0;
    n_count = m_count; n_ctrl = m_ctrl; n_pend = m_pend;
    if (tick) begin
      if (m_count != 0) n_count = m_count - 1;
      else begin
        n_pend = 1;
        if (m_ctrl[1]) n_count = m_load;
        else n_ctrl[0] = 0;
      end
    end
    if (acc && we) begin
      case (idx)
        0: if (sel[0]) n_ctrl = wdat[2:0];
        1: m_load = lanes(m_load, wdat, sel);
        2: n_count = lanes(m_count, wdat, sel);
        3: if (sel[0] && wdat[0] && !expire) n_pend = 0;
        4: m_pre = int'(lanes(32'(m_pre), wdat, sel) & 32'hFFFF);
        default: ;
      endcase
    end
    m_dat = (acc && !we) ? rdv : 0;
    m_ack = acc; m_count = n_count; m_ctrl = n_ctrl; m_pend = n_pend; m_pcnt = n_pcnt;
    m_irq = n_pend && n_ctrl[2];
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("ack_vs_model", 32'(ack), 32'(m_ack));
      check("rdata_vs_model", rdat, m_dat);
      check("irq_vs_model", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic bus(input logic [2:0] idx, input logic w, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    int n;
    adr = {27'b0, idx, 2'b00}; we = w; sel = s; wdat = d; cyc = 1; stb = 1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 16);
    check("bus_ack_seen", 32'(ack), 32'd1);
    r = rdat;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] r;
    bus(idx, 1'b1, 4'hF, d, r);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    bus(idx, 1'b0, 4'hF, 32'h0, r);
    check(name, r, exp);
  endtask

  task automatic wait_irq(input int lim, output int t);
    int n;
    n = 0;
    while (!irq && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("irq_arrived", 32'(irq), 32'd1);
    t = cyc_n;
  endtask

  initial begin
    int t0, t1, t2, k;
    logic [31:0] r;
    rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_rdata", rdat, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rst_n = 1;
    rd_chk("reset_ctrl", REG_CTRL, 32'h0);
    rd_chk("reset_load", REG_LOAD, 32'h10);
    rd_chk("reset_count", REG_COUNT, 32'h10);
    rd_chk("reset_prescale", REG_PRESCALE, 32'h3);

    // Auto-reload, tick every cycle: expiry 6 cycles after enable, then every 6.
    wr(REG_PRESCALE, 0); wr(REG_LOAD, 5); wr(REG_COUNT, 5); wr(REG_CTRL, 7);
    t0 = cyc_n;
    wait_irq(20, t1);
    check("auto_first_irq_delay", 32'(t1 - t0), 32'd6);
    wr(REG_STATUS, 1);
    wait_irq(20, t2);
    check("auto_second_irq_delay", 32'(t2 - t0), 32'd12);
    rd_chk("auto_count_reloaded", REG_COUNT, 32'd5);

    // One-shot with PRESCALE=3: ticks every 4 cycles, expiry on the third tick.
    wr(REG_CTRL, 0); wr(REG_STATUS, 1); wr(REG_PRESCALE, 3); wr(REG_COUNT, 2); wr(REG_CTRL, 5);
    t0 = cyc_n;
    wait_irq(40, t1);
    check("oneshot_irq_delay", 32'(t1 - t0), 32'd12);
    rd_chk("oneshot_ctrl_en_cleared", REG_CTRL, 32'h4);
    rd_chk("oneshot_count_zero", REG_COUNT, 32'h0);

    // Byte lanes and ack spacing.
    wr(REG_LOAD, 0);
    bus(REG_LOAD, 1'b1, 4'b0101, 32'hAABB_CCDD, r);
    rd_chk("load_byte_lanes", REG_LOAD, 32'h00BB_00DD);
    @(negedge clk);
    adr = 32'h4; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("held_stb_ack_pattern", 32'(ack), 32'((i % 2) == 0));
    end
    cyc = 0; stb = 0;

    // W1C lands on the expiry edge: the set wins.
    wr(REG_CTRL, 0); wr(REG_STATUS, 1); wr(REG_PRESCALE, 0); wr(REG_LOAD, 3); wr(REG_COUNT, 3);
    wr(REG_CTRL, 3);
    repeat (3) @(negedge clk);
    wr(REG_STATUS, 1);
    rd_chk("w1c_vs_set_pend", REG_STATUS, 32'h1);

    // COUNT write lands on a tick (PRESCALE=7, tick 8 cycles after enable).
    wr(REG_CTRL, 0); wr(REG_STATUS, 1); wr(REG_PRESCALE, 7); wr(REG_LOAD, 100); wr(REG_COUNT, 100);
    wr(REG_CTRL, 3);
    repeat (7) @(negedge clk);
    wr(REG_COUNT, 9);
    rd_chk("count_write_vs_tick", REG_COUNT, 32'd9);

    // CTRL write lands on a one-shot expiry: the bus value wins.
    wr(REG_CTRL, 0); wr(REG_PRESCALE, 0); wr(REG_COUNT, 2); wr(REG_CTRL, 5);
    repeat (2) @(negedge clk);
    wr(REG_CTRL, 3);
    rd_chk("ctrl_write_vs_expiry", REG_CTRL, 32'h3);

    // PRESCALE lowered below the running prescaler: no tick until the 16-bit wrap.
    wr(REG_CTRL, 0); wr(REG_STATUS, 1); wr(REG_PRESCALE, 10); wr(REG_COUNT, 0); wr(REG_CTRL, 5);
    t0 = cyc_n;
    repeat (4) @(negedge clk);
    wr(REG_PRESCALE, 2);
    wait_irq(70000, t1);
    check("prescale_wrap_irq_delay", 32'(t1 - t0), 32'd65539);

    rd_chk("unmapped_0x1c_reads_zero", 3'd7, 32'h0);

    // Reset in the middle of a LOAD write: no ack, nothing written.
    adr = 32'h4; we = 1; sel = 4'hF; wdat = 32'h1234_5678; cyc = 1; stb = 1;
    #2 rst_n = 0;
    @(negedge clk);
    check("reset_aborts_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("reset_aborts_ack_later", 32'(ack), 32'd0);
    cyc = 0; stb = 0; we = 0;
    rst_n = 1;
    rd_chk("post_reset_load", REG_LOAD, 32'h10);
    rd_chk("post_reset_count", REG_COUNT, 32'h10);
    rd_chk("post_reset_prescale", REG_PRESCALE, 32'h3);
    rd_chk("post_reset_ctrl", REG_CTRL, 32'h0);
    rd_chk("post_reset_status", REG_STATUS, 32'h0);

    // Random bus traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      k    = int'($urandom_range(0, 7));
      adr  = ($urandom() & 32'hFFFF_FFE3) | (32'(k) << 2);
      case (k)
        1, 2:    wdat = 32'($urandom_range(0, 15));
        4:       wdat = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: wdat = $urandom();
      endcase
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      if (i % 1000 == 999) begin
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
